// File: rtl/weight_bram_sequencer_if.sv
// Handshake, BRAM and MAC-side signals of the weight sequencer.
// CHECKSUM exists only when WEIGHT_SEQ_CHECKSUM_EN is defined.
interface weight_bram_sequencer_if #(
   parameter int AW = 5,
   parameter int DW = 16
);
   logic          START;
   logic          LOAD_REQ;
   logic [DW-1:0] LOAD_DATA;
   logic          LOAD_VALID;
   logic          LOAD_READY;
   logic [AW-1:0] BRAM_ADDR;
   logic [DW-1:0] BRAM_DI;
   logic          BRAM_EN;
   logic          BRAM_WE;
   logic [DW-1:0] BRAM_DO;
   logic [DW-1:0] W_DATA;
   logic [AW-1:0] W_INDEX;
   logic          W_LAST;
   logic          W_VALID;
   logic          W_READY;
   logic          BUSY;
   logic          DONE;
`ifdef WEIGHT_SEQ_CHECKSUM_EN
   logic [DW-1:0] CHECKSUM;
`endif

   modport master (
      input  START, LOAD_REQ, LOAD_DATA, LOAD_VALID, BRAM_DO, W_READY,
      output LOAD_READY, BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE,
             W_DATA, W_INDEX, W_LAST, W_VALID, BUSY, DONE
`ifdef WEIGHT_SEQ_CHECKSUM_EN
      , output CHECKSUM
`endif
   );

   modport slave (
      output START, LOAD_REQ, LOAD_DATA, LOAD_VALID, BRAM_DO, W_READY,
      input  LOAD_READY, BRAM_ADDR, BRAM_DI, BRAM_EN, BRAM_WE,
             W_DATA, W_INDEX, W_LAST, W_VALID, BUSY, DONE
`ifdef WEIGHT_SEQ_CHECKSUM_EN
      , input CHECKSUM
`endif
   );
endinterface

// File: rtl/weight_bram_sequencer.sv
// Load/run controller for one neuron's single-port weight BRAM feeding the MAC.
// Optional WEIGHT_SEQ_CHECKSUM_EN adds a per-pass mod-2^DW CHECKSUM output.
module weight_bram_sequencer #(
   parameter int DEPTH = 28,
   parameter int AW    = 5,
   parameter int DW    = 16
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   weight_bram_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

   // one spare bit so the counter can reach DEPTH even when DEPTH == 2**AW
   localparam int            CW   = AW + 1;
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   state_t             state, state_n;
   logic [CW-1:0]      cnt;
   logic               issue, wr, done_n, load_ready;
   logic               bram_en, bram_we, done;
   logic [AW-1:0]      bram_addr;
   logic [DW-1:0]      bram_di;
   logic               inflight;
   logic [AW-1:0]      inflight_idx;
   logic [1:0][DW-1:0] buf_data;
   logic [1:0][AW-1:0] buf_idx;
   logic               rd_ptr, wr_ptr;
   logic [1:0]         buf_cnt;
   logic               w_valid, push, pop;
   logic [2:0]         occ_after;

   assign w_valid = (buf_cnt != 2'd0);
   assign push    = inflight;
   assign pop     = w_valid && bus.W_READY;
   // occupancy once this cycle's pop and the in-flight capture have landed
   assign occ_after = {1'b0, buf_cnt} - {2'b0, pop} + {2'b0, inflight};

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n    = state;
      issue      = 1'b0;
      wr         = 1'b0;
      done_n     = 1'b0;
      load_ready = 1'b0;
      case (state)
         IDLE: begin
            if (bus.LOAD_REQ) begin
               state_n = LOAD;
            end else if (bus.START) begin
               // address 0 is issued straight away so data lands 2 cycles after START
               issue   = 1'b1;
               state_n = (DEPTH == 1) ? DRAIN : RUN;
            end
         end
         LOAD: begin
            if (cnt == FULL) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else begin
               load_ready = 1'b1;
               wr         = bus.LOAD_VALID;
            end
         end
         RUN: begin
            if (occ_after < 3'd2) begin
               issue = 1'b1;
               if (cnt == LAST) state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (occ_after == 3'd0) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         bram_en      <= 1'b0;
         bram_we      <= 1'b0;
         bram_addr    <= '0;
         bram_di      <= '0;
         cnt          <= '0;
         inflight     <= 1'b0;
         inflight_idx <= '0;
         done         <= 1'b0;
         buf_data     <= '0;
         buf_idx      <= '0;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         buf_cnt      <= 2'd0;
      end else begin
         bram_en  <= issue | wr;
         bram_we  <= wr;
         done     <= done_n;
         inflight <= issue;
         if (issue | wr) bram_addr <= cnt[AW-1:0];
         if (wr)         bram_di   <= bus.LOAD_DATA;
         if (issue)      inflight_idx <= cnt[AW-1:0];
         if (done_n)            cnt <= '0;
         else if (issue | wr)   cnt <= cnt + 1'b1;
         if (push) begin
            buf_data[wr_ptr] <= bus.BRAM_DO;
            buf_idx[wr_ptr]  <= inflight_idx;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   assign bus.LOAD_READY = load_ready;
   assign bus.BRAM_EN    = bram_en;
   assign bus.BRAM_WE    = bram_we;
   assign bus.BRAM_ADDR  = bram_addr;
   assign bus.BRAM_DI    = bram_di;
   assign bus.W_VALID    = w_valid;
   assign bus.W_DATA     = buf_data[rd_ptr];
   assign bus.W_INDEX    = buf_idx[rd_ptr];
   assign bus.W_LAST     = w_valid && (buf_idx[rd_ptr] == AW'(DEPTH - 1));
   assign bus.BUSY       = (state != IDLE);
   assign bus.DONE       = done;

`ifdef WEIGHT_SEQ_CHECKSUM_EN
   logic [DW-1:0] csum;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)
         csum <= '0;
      else if (state == IDLE && state_n != IDLE)
         csum <= '0;
      else
         csum <= csum + (wr ? bus.LOAD_DATA : DW'(0)) + (pop ? buf_data[rd_ptr] : DW'(0));
   end

   assign bus.CHECKSUM = csum;
`endif
endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Directed bench for weight_bram_sequencer with a negedge BRAM model and a
// table of hand-computed per-cycle outputs for the backpressured run.
module tb_weight_bram_sequencer;
  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int NV    = 12;

  typedef struct {
    logic          rdy;
    logic          vld;
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } vec_t;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  int   cyc  = 0;
  int   npass = 0;
  int   ntot  = 0;
  vec_t tbl [NV];
  logic [DW-1:0] exp_base;
  bit            exp_inc;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  weight_bram_sequencer_if #(.AW(AW), .DW(DW)) bus ();
  weight_bram_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus)
  );

  logic [DW-1:0] mem [2**AW];
  always @(negedge CLK) begin
    if (bus.BRAM_EN) begin
      if (bus.BRAM_WE) mem[bus.BRAM_ADDR] <= bus.BRAM_DI;
      else             bus.BRAM_DO <= mem[bus.BRAM_ADDR];
    end
  end

  // monitor: logs writes, pops and DONE pulses; tracks outstanding reads
  int   done_cnt = 0, done_cyc = 0, rd_issued = 0, popped = 0, max_out = 0;
  int   stab_err = 0, idle_en_err = 0;
  logic busy_at_done = 1'b0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] prev_idx = '0;
  int wr_addr[$], wr_data[$], wr_cyc[$];
  int pop_idx[$], pop_data[$], pop_last[$], pop_cyc[$];

  always @(negedge CLK) begin
    if (!RSTN) begin
      rd_issued  <= 0;
      popped     <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (bus.DONE) begin
        done_cnt     <= done_cnt + 1;
        done_cyc     <= cyc;
        busy_at_done <= bus.BUSY;
      end
      if (!bus.BUSY && bus.BRAM_EN) idle_en_err <= idle_en_err + 1;
      if (bus.BRAM_EN && bus.BRAM_WE) begin
        wr_addr.push_back(int'(bus.BRAM_ADDR));
        wr_data.push_back(int'(bus.BRAM_DI));
        wr_cyc.push_back(cyc);
      end
      if (bus.BRAM_EN && !bus.BRAM_WE) rd_issued <= rd_issued + 1;
      if (rd_issued + ((bus.BRAM_EN && !bus.BRAM_WE) ? 1 : 0) - popped > max_out)
        max_out <= rd_issued + ((bus.BRAM_EN && !bus.BRAM_WE) ? 1 : 0) - popped;
      if (prev_stall && (bus.W_DATA !== prev_data || bus.W_INDEX !== prev_idx))
        stab_err <= stab_err + 1;
      prev_stall <= bus.W_VALID && !bus.W_READY;
      prev_data  <= bus.W_DATA;
      prev_idx   <= bus.W_INDEX;
      if (bus.W_VALID && bus.W_READY) begin
        pop_idx.push_back(int'(bus.W_INDEX));
        pop_data.push_back(int'(bus.W_DATA));
        pop_last.push_back(int'(bus.W_LAST));
        pop_cyc.push_back(cyc);
        popped <= popped + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [DW-1:0] word(input int i);
    return exp_inc ? exp_base + DW'(i) : exp_base;
  endfunction

  function automatic logic [DW-1:0] exp_sum();
    logic [DW-1:0] s = '0;
    for (int i = 0; i < DEPTH; i++) s = s + word(i);
    return s;
  endfunction

  task automatic do_load(input string nm, input bit also_start);
    int l, bw, bd, bp, err, rdy_err, k;
    bw = wr_addr.size(); bd = done_cnt; bp = pop_idx.size();
    err = 0; rdy_err = 0;
    bus.LOAD_REQ = 1'b1; bus.START = also_start; l = cyc;
    tick();
    bus.LOAD_REQ = 1'b0; bus.START = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.LOAD_VALID = 1'b1; bus.LOAD_DATA = word(i);
      @(negedge CLK);
      if (bus.LOAD_READY !== 1'b1 || bus.W_VALID !== 1'b0) rdy_err++;
      tick();
    end
    bus.LOAD_VALID = 1'b0;
    k = 0;
    while (done_cnt == bd && k < 20) begin tick(); k++; end
    repeat (2) tick();
    chk({nm, "_done_count"}, 32'(done_cnt - bd), 32'd1);
    chk({nm, "_done_cycle"}, 32'(done_cyc), 32'(l + 30));
    chk({nm, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({nm, "_ready_novalid"}, 32'(rdy_err), 32'd0);
    chk({nm, "_write_count"}, 32'(wr_addr.size() - bw), 32'(DEPTH));
    if (wr_addr.size() - bw == DEPTH) begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_addr[bw+i] != i || wr_data[bw+i] != int'(word(i)) || wr_cyc[bw+i] != l + 2 + i) err++;
    end else err++;
    chk({nm, "_write_seq"}, 32'(err), 32'd0);
    chk({nm, "_no_pops"}, 32'(pop_idx.size() - bp), 32'd0);
`ifdef WEIGHT_SEQ_CHECKSUM_EN
    chk({nm, "_checksum"}, 32'(bus.CHECKSUM), 32'(exp_sum()));
`endif
  endtask

  task automatic run_pass(input string nm, input bit bp, input bit inj_start);
    int s, k, bw, bd, bpop, err, n;
    bit [3:0] pat;
    pat = 4'b1001;
    bw = wr_addr.size(); bd = done_cnt; bpop = pop_idx.size(); err = 0;
    bus.START = 1'b1; s = cyc;
    tick();
    bus.START = 1'b0;
    k = 0;
    while (done_cnt == bd && k < 300) begin
      if (!bp)         bus.W_READY = 1'b1;
      else if (k == 0) bus.W_READY = 1'b0;
      else if (k <= NV) bus.W_READY = tbl[k-1].rdy;
      else             bus.W_READY = pat[(k-1)%4];
      bus.START = (inj_start && k == 8);
      @(negedge CLK);
      if (bp && k >= 1 && k <= NV) begin
        chk($sformatf("%s_row%0d_valid", nm, k-1), 32'(bus.W_VALID), 32'(tbl[k-1].vld));
        chk($sformatf("%s_row%0d_index", nm, k-1), 32'(bus.W_INDEX), 32'(tbl[k-1].idx));
        chk($sformatf("%s_row%0d_data", nm, k-1), 32'(bus.W_DATA), 32'(tbl[k-1].data));
      end
      tick();
      k++;
    end
    bus.START = 1'b0; bus.W_READY = 1'b1;
    repeat (3) tick();
    n = pop_idx.size() - bpop;
    chk({nm, "_done_count"}, 32'(done_cnt - bd), 32'd1);
    chk({nm, "_pop_count"}, 32'(n), 32'(DEPTH));
    for (int i = 0; i < n; i++)
      if (pop_idx[bpop+i] != i || pop_data[bpop+i] != int'(word(i)) ||
          pop_last[bpop+i] != ((i == DEPTH-1) ? 1 : 0)) err++;
    chk({nm, "_order_data_last"}, 32'(err), 32'd0);
    if (n > 0) chk({nm, "_done_after_last"}, 32'(done_cyc), 32'(pop_cyc[pop_cyc.size()-1] + 1));
    if (!bp && n > 0) begin
      chk({nm, "_first_valid"}, 32'(pop_cyc[bpop]), 32'(s + 2));
      chk({nm, "_done_cycle"}, 32'(done_cyc), 32'(s + 30));
    end
    chk({nm, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({nm, "_no_writes"}, 32'(wr_addr.size() - bw), 32'd0);
`ifdef WEIGHT_SEQ_CHECKSUM_EN
    chk({nm, "_checksum"}, 32'(bus.CHECKSUM), 32'(exp_sum()));
`endif
  endtask

  initial begin
    int s, k, bd;
    // W_READY pattern 1,0,0,1 from the first valid cycle: two words per four cycles
    tbl[0]  = '{1'b1, 1'b1, 5'd0, 16'h0100};
    tbl[1]  = '{1'b0, 1'b1, 5'd1, 16'h0101};
    tbl[2]  = '{1'b0, 1'b1, 5'd1, 16'h0101};
    tbl[3]  = '{1'b1, 1'b1, 5'd1, 16'h0101};
    tbl[4]  = '{1'b1, 1'b1, 5'd2, 16'h0102};
    tbl[5]  = '{1'b0, 1'b1, 5'd3, 16'h0103};
    tbl[6]  = '{1'b0, 1'b1, 5'd3, 16'h0103};
    tbl[7]  = '{1'b1, 1'b1, 5'd3, 16'h0103};
    tbl[8]  = '{1'b1, 1'b1, 5'd4, 16'h0104};
    tbl[9]  = '{1'b0, 1'b1, 5'd5, 16'h0105};
    tbl[10] = '{1'b0, 1'b1, 5'd5, 16'h0105};
    tbl[11] = '{1'b1, 1'b1, 5'd5, 16'h0105};

    bus.START = 1'b0; bus.LOAD_REQ = 1'b0; bus.LOAD_DATA = '0;
    bus.LOAD_VALID = 1'b0; bus.W_READY = 1'b1;
    exp_base = 16'h0100; exp_inc = 1'b1;

    #2;
    chk("rst_busy",       32'(bus.BUSY),       32'd0);
    chk("rst_done",       32'(bus.DONE),       32'd0);
    chk("rst_w_valid",    32'(bus.W_VALID),    32'd0);
    chk("rst_w_data",     32'(bus.W_DATA),     32'd0);
    chk("rst_bram_en",    32'(bus.BRAM_EN),    32'd0);
    chk("rst_bram_we",    32'(bus.BRAM_WE),    32'd0);
    chk("rst_bram_addr",  32'(bus.BRAM_ADDR),  32'd0);
    chk("rst_load_ready", 32'(bus.LOAD_READY), 32'd0);
    #20 RSTN = 1'b1;
    tick();

    do_load("load", 1'b0);
    run_pass("run", 1'b0, 1'b0);
    run_pass("bp", 1'b1, 1'b0);
    chk("bp_outstanding_le2", 32'(max_out <= 2), 32'd1);
    chk("bp_stall_stable", 32'(stab_err), 32'd0);
    do_load("arb_load", 1'b1);
    run_pass("run_start_ign", 1'b0, 1'b1);

    // reset while index 10 is at the head
    bd = done_cnt;
    bus.START = 1'b1; s = cyc;
    tick();
    bus.START = 1'b0;
    k = 0;
    while (!(bus.W_VALID && bus.W_INDEX == 5'd10) && k < 60) begin tick(); k++; end
    chk("rstmid_reached_idx10", 32'(k < 60), 32'd1);
    #2 RSTN = 1'b0;
    #1;
    chk("rstmid_w_valid", 32'(bus.W_VALID), 32'd0);
    chk("rstmid_w_data",  32'(bus.W_DATA),  32'd0);
    chk("rstmid_w_index", 32'(bus.W_INDEX), 32'd0);
    chk("rstmid_bram_en", 32'(bus.BRAM_EN), 32'd0);
    chk("rstmid_busy",    32'(bus.BUSY),    32'd0);
    @(posedge CLK);
    #3 RSTN = 1'b1;
    repeat (4) tick();
    chk("rstmid_no_done", 32'(done_cnt - bd), 32'd0);
    run_pass("run_after_rst", 1'b0, 1'b0);

`ifdef WEIGHT_SEQ_CHECKSUM_EN
    exp_base = 16'h0FFF; exp_inc = 1'b0;
    do_load("cs_load", 1'b0);
    chk("cs_load_const", 32'(bus.CHECKSUM), 32'h0000BFE4);
    run_pass("cs_run", 1'b0, 1'b0);
    chk("cs_run_const", 32'(bus.CHECKSUM), 32'h0000BFE4);
`endif

    chk("en_never_in_idle", 32'(idle_en_err), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/weight_bram_sequencer.md
Name: weight_bram_sequencer

Overview:
Controller that owns one single-port weight BRAM (28 x 16-bit, negedge-clocked, EN/WE/ADDR/DI/DO) for one ANN neuron.
- Load mode: writes a streamed weight set into the BRAM.
- Run mode: reads all weights in address order into the MAC datapath through a 2-entry output buffer with valid/ready backpressure.
- Sits between the layer control FSM / host loader and the BRAM plus MAC.

Parameters:
DEPTH, 28, number of weights (BRAM words); last address = DEPTH-1
AW, 5, BRAM address width; requires 2^AW >= DEPTH
DW, 16, weight word width

Ports:
CLK  in  1  system clock; all controller flops on posedge
RSTN  in  1  asynchronous active-low reset
START  in  1  one-cycle pulse; begin a run (read) pass
LOAD_REQ  in  1  one-cycle pulse; begin a load (write) pass
LOAD_DATA  in  DW  weight word to write
LOAD_VALID  in  1  LOAD_DATA valid
LOAD_READY  out  1  controller accepts LOAD_DATA this cycle
BRAM_ADDR  out  AW  to BRAM ADDR
BRAM_DI  out  DW  to BRAM DI
BRAM_EN  out  1  to BRAM EN
BRAM_WE  out  1  to BRAM WE
BRAM_DO  in  DW  from BRAM DO
W_DATA  out  DW  weight to MAC
W_INDEX  out  AW  address W_DATA came from
W_LAST  out  1  W_DATA is index DEPTH-1
W_VALID  out  1  W_DATA/W_INDEX/W_LAST valid
W_READY  in  1  MAC consumes the head entry when W_VALID && W_READY
BUSY  out  1  state != IDLE
DONE  out  1  one-cycle pulse at the end of a load or run pass

Behaviour:
- Reset (RSTN low, async): state IDLE; all outputs 0; address counter 0; output buffer empty; in-flight flag 0.
- BRAM timing: BRAM_ADDR/EN/WE/DI are registered on posedge and held stable across the following negedge. A read issued at posedge k appears on BRAM_DO and is captured at posedge k+1. Read latency is fixed at 1 cycle.
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - LOAD_REQ -> LOAD.
  - else START -> RUN.
  - LOAD_REQ wins if both pulse in the same cycle.
  - START and LOAD_REQ are ignored in every non-IDLE state.
- LOAD:
  - LOAD_READY=1.
  - On each LOAD_VALID: drive EN=1, WE=1, ADDR=cnt, DI=LOAD_DATA for exactly one cycle, then cnt++.
  - With no LOAD_VALID: EN=0.
  - After the write at cnt=DEPTH-1 -> IDLE, DONE pulse, cnt=0.
  - W_VALID stays 0 throughout.
- RUN:
  - WE=0.
  - Issue a read (EN=1, ADDR=cnt) when (entries in buffer + in-flight) < 2, counted after this cycle's pop; then cnt++.
  - The captured BRAM_DO is pushed with INDEX=issued address and LAST=(address==DEPTH-1).
  - After issuing address DEPTH-1 -> DRAIN.
- DRAIN:
  - EN=0.
  - When the buffer is empty and nothing is in flight -> IDLE, DONE pulse, cnt=0.
- Output buffer:
  - 2-entry FIFO; head drives W_*.
  - Push and pop in the same cycle are both honoured.
  - Never overflows, by construction of the credit rule.
  - Order is strictly ascending index.
- Throughput: with W_READY held 1, one weight per cycle. First W_VALID appears 2 cycles after the START cycle. DONE pulses 1 cycle after W_LAST is consumed.
- W_READY low stalls issue within at most 2 reads. W_DATA holds stable while W_VALID && !W_READY.
- Reset mid-pass: the pass is abandoned, BRAM_EN drops asynchronously to 0, buffer is flushed, and no DONE is produced. A partially loaded BRAM keeps the words already written.
- BRAM_EN is never 1 in IDLE. BRAM_WE is never 1 outside LOAD.

Optional Feature:
WEIGHT_SEQ_CHECKSUM_EN
- Defined: adds output CHECKSUM [DW-1:0], the mod-2^DW sum of every word written (LOAD) or popped (RUN) in the current pass. It clears when a pass starts, is valid and held from the DONE pulse until the next pass, and is 0 on reset.
- Undefined: no CHECKSUM port and no adder logic.

Test Plan:
- Load pass: LOAD_REQ, then 28 words 0x0100+i with LOAD_VALID continuous -> WE pulses at ADDR 0..27 with DI=0x0100+i; DONE 1 cycle after the last write; BUSY=0 after.
- Run pass with W_READY=1 after the above load -> W_DATA 0x0100..0x011B on 28 consecutive cycles, W_INDEX 0..27, W_LAST only on index 27, exactly one DONE pulse.
- Backpressure: W_READY toggled 1,0,0,1 repeatedly -> no lost or duplicated word, in-order indices, at most 2 reads outstanding, W_DATA stable while stalled.
- Arbitration: START and LOAD_REQ in the same IDLE cycle -> LOAD entered; START pulsed during RUN -> ignored, still 28 words and one DONE.
- Reset mid-run: RSTN low at index 10 -> all outputs 0 immediately; new START -> fresh pass from index 0 with the loaded data intact.
- Checksum (macro defined): load 28 words of 0x0FFF -> CHECKSUM 0xBFE4 at DONE; the run pass reports the same value.
